// File: rtl/seq_pkg.sv
// Shared types and constants for the instruction sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_pkg;

    localparam int INSTR_W = 16;
    localparam int OP_W    = 4;

    localparam logic [OP_W-1:0] OP_LOAD        = 4'd0;
    localparam logic [OP_W-1:0] OP_STORE       = 4'd1;
    localparam logic [OP_W-1:0] OP_CMP         = 4'd12;
    localparam logic [OP_W-1:0] OP_ILLEGAL_MIN = 4'd13;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_CTRL_WAIT,
        ST_MEM,
        ST_WB,
        ST_NEXT,
        ST_HALT
    } seqState_t;

    // Opcodes 13..15 have no defined meaning in the instruction set.
    function automatic logic isIllegalOp(input logic [OP_W-1:0] op);
        return op >= OP_ILLEGAL_MIN;
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Bundle of control-unit, instruction-memory and data-memory signals around the sequencer.
// Latency: n/a (wiring only).
// Backpressure: imem/dmem requests are held until the matching ack; control unit gates via readInst_flag.
interface instr_sequencer_if #(parameter int AW = 8);

    logic                        start;
    logic                        stop;
    logic                        readInst_flag;
    logic                        memRead;
    logic                        memWrite;
    logic                        memReadWrite;
    logic                        WBSrc;
    logic                        isALUOP;
    logic                        isLoadStore;
    logic [3:0]                  opcode;
    logic                        decodedInst;
    logic                        fetchNextInst;
    logic [AW-1:0]               imem_addr;
    logic                        imem_req;
    logic                        imem_ack;
    logic [seq_pkg::INSTR_W-1:0] imem_rdata;
    logic [seq_pkg::INSTR_W-1:0] ir;
    logic                        dmem_req;
    logic                        dmem_we;
    logic                        dmem_ack;
    logic                        reg_we;
    logic                        wb_sel;
    logic                        busy;
    logic                        halted;
    logic                        illegal;
    logic [15:0]                 retired_count;

    // Sequencer side.
    modport master (
        input  start, stop, readInst_flag, memRead, memWrite, memReadWrite,
               WBSrc, isALUOP, isLoadStore, imem_ack, imem_rdata, dmem_ack,
        output opcode, decodedInst, fetchNextInst, imem_addr, imem_req, ir,
               dmem_req, dmem_we, reg_we, wb_sel, busy, halted, illegal,
               retired_count
    );

    // Environment side: control unit, memories and datapath.
    modport slave (
        output start, stop, readInst_flag, memRead, memWrite, memReadWrite,
               WBSrc, isALUOP, isLoadStore, imem_ack, imem_rdata, dmem_ack,
        input  opcode, decodedInst, fetchNextInst, imem_addr, imem_req, ir,
               dmem_req, dmem_we, reg_we, wb_sel, busy, halted, illegal,
               retired_count
    );

endinterface

// File: rtl/seq_pc.sv
// Program counter with parallel load and increment, wrapping modulo 2^AW.
// Latency: 1 cycle from load/inc to new pc value.
// Backpressure: none; updates only when told to.
module seq_pc #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [AW-1:0] loadVal,
    input  logic          inc,
    output logic [AW-1:0] pc
);

    // PC register; load has priority over increment, overflow wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= '0;
        end else if (load) begin
            pc <= loadVal;
        end else if (inc) begin
            pc <= pc + AW'(1);
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode sequencer: fetches instructions, presents opcode, steps memory access and writeback.
// Latency: 5 cycles per ALU instruction best case; loads add MEM cycles, stores skip WB.
// Backpressure: holds imem_req/dmem_req until ack; waits in CTRL_WAIT while readInst_flag is high.
// Build option SEQ_ILLEGAL_TRAP_EN: opcodes 13..15 trap to HALT; otherwise they retire as NOPs.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int AW = 8
) (
    input logic                clk,
    input logic                rst,
    instr_sequencer_if.master  bus
);

    seqState_t            state;
    seqState_t            stateNxt;
    seqState_t            ctrlTarget;
    logic [AW-1:0]        pc;
    logic                 fetchDone;
    logic [INSTR_W-1:0]   irReg;
    logic [OP_W-1:0]      opReg;
    logic [15:0]          retiredCnt;

    // isALUOP carries no sequencing decision; the datapath consumes it directly.
    wire unusedAluFlag = &{1'b0, bus.isALUOP};

    // Request is only raised once the control unit allows the next fetch.
    assign fetchDone = (state == ST_FETCH) && bus.readInst_flag && bus.imem_ack;

    seq_pc #(.AW(AW)) uPc (
        .clk     (clk),
        .rst     (rst),
        .load    (1'b0),
        .loadVal ({AW{1'b0}}),
        .inc     (fetchDone),
        .pc      (pc)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNxt;
        end
    end

    // Next-state logic for the instruction life cycle.
    always_comb begin
        stateNxt   = state;
        ctrlTarget = ST_NEXT;
        if (bus.isLoadStore) begin
            ctrlTarget = ST_MEM;
        end else if (bus.memReadWrite) begin
            ctrlTarget = ST_WB;
        end
        case (state)
            ST_IDLE: begin
                if (bus.start && !bus.stop && bus.readInst_flag) begin
                    stateNxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (fetchDone) begin
                    stateNxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                stateNxt = ST_CTRL_WAIT;
            end
            ST_CTRL_WAIT: begin
`ifdef SEQ_ILLEGAL_TRAP_EN
                if (isIllegalOp(opReg)) begin
                    stateNxt = ST_HALT;
                end else if (!bus.readInst_flag) begin
                    stateNxt = ctrlTarget;
                end
`else
                if (!bus.readInst_flag) begin
                    stateNxt = isIllegalOp(opReg) ? ST_NEXT : ctrlTarget;
                end
`endif
            end
            ST_MEM: begin
                if (bus.dmem_ack) begin
                    stateNxt = bus.memRead ? ST_WB : ST_NEXT;
                end
            end
            ST_WB: begin
                stateNxt = ST_NEXT;
            end
            ST_NEXT: begin
                stateNxt = bus.stop ? ST_IDLE : ST_FETCH;
            end
            ST_HALT: begin
                stateNxt = ST_HALT;
            end
            default: begin
                stateNxt = ST_IDLE;
            end
        endcase
    end

    // Instruction, opcode and retirement-count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            irReg      <= '0;
            opReg      <= '0;
            retiredCnt <= '0;
        end else begin
            if (fetchDone) begin
                irReg <= bus.imem_rdata;
            end
            if (state == ST_DECODE) begin
                opReg <= irReg[INSTR_W-1 -: OP_W];
            end
            if (state == ST_NEXT) begin
                retiredCnt <= retiredCnt + 16'd1;
            end
        end
    end

`ifdef SEQ_ILLEGAL_TRAP_EN
    logic trapNow;
    logic haltedReg;
    logic illegalReg;

    assign trapNow = (state == ST_CTRL_WAIT) && isIllegalOp(opReg);

    // Sticky trap flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            haltedReg  <= 1'b0;
            illegalReg <= 1'b0;
        end else if (trapNow) begin
            haltedReg  <= 1'b1;
            illegalReg <= 1'b1;
        end
    end

    assign bus.halted  = haltedReg;
    assign bus.illegal = illegalReg;
`else
    assign bus.halted  = 1'b0;
    assign bus.illegal = 1'b0;
`endif

    assign bus.imem_addr     = pc;
    assign bus.imem_req      = (state == ST_FETCH) && bus.readInst_flag;
    assign bus.ir            = irReg;
    assign bus.opcode        = opReg;
    assign bus.decodedInst   = (state == ST_DECODE);
    assign bus.fetchNextInst = (state == ST_NEXT);
    assign bus.dmem_req      = (state == ST_MEM);
    assign bus.dmem_we       = (state == ST_MEM) && bus.memWrite;
    assign bus.reg_we        = (state == ST_WB);
    assign bus.wb_sel        = (state == ST_WB) && bus.WBSrc;
    assign bus.busy          = (state != ST_IDLE) && (state != ST_HALT);
    assign bus.retired_count = retiredCnt;

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized bench for instr_sequencer against a per-instruction timing/behaviour model.
// Latency: n/a.
// Backpressure: bench plays control unit and both memories with random ack/flag delays.
module tb_instr_sequencer;
    import seq_pkg::*;

    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    instr_sequencer_if #(.AW(AW)) bus();

    instr_sequencer #(.AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checkCnt = 0;
    int errCnt   = 0;

    logic [AW-1:0] modelPc      = '0;
    logic [15:0]   modelRetired = '0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs;
        bus.start         = 1'b0;
        bus.stop          = 1'b0;
        bus.readInst_flag = 1'b0;
        bus.memRead       = 1'b0;
        bus.memWrite      = 1'b0;
        bus.memReadWrite  = 1'b0;
        bus.WBSrc         = 1'b0;
        bus.isALUOP       = 1'b0;
        bus.isLoadStore   = 1'b0;
        bus.imem_ack      = 1'b0;
        bus.imem_rdata    = '0;
        bus.dmem_ack      = 1'b0;
    endtask

    // One instruction from its first FETCH cycle to retirement (or trap).
    // iDly: imem cycles without ack; cDly: extra cycles control unit keeps readInst_flag high
    // after decodedInst; dDly: dmem cycles without ack.
    task automatic runInstr(input logic [15:0] word, input bit ls, input bit mr, input bit mw,
                            input bit mrw, input bit wbs, input int iDly, input int cDly,
                            input int dDly, input bit stopInMem);
        int cyc = 0;
        int decodeCyc = -1;
        int fetchCyc = -1;
        int dmemCyc = 0;
        int regWeCnt = 0;
        int nextCnt = 0;
        int iWait = 0;
        int cCnt = 0;
        int overlap = 0;
        int weBad = 0;
        int selBad = 0;
        bit reqSeen = 1'b0;
        bit decSeen = 1'b0;
        bit halt = 1'b0;
        logic [AW-1:0] firstAddr = '0;
        logic [3:0] opSeen = '0;
        logic [3:0] op = word[15:12];
        bit expNop;
        bit expTrap;
        int expDmem;
        int expWb;
        int expLat;

        // Reference: what this instruction should do, from the instruction-level rules.
        expNop  = (int'(op) >= 13);
        expTrap = 1'b0;
`ifdef SEQ_ILLEGAL_TRAP_EN
        expTrap = expNop;
`endif
        expDmem = (!expNop && ls) ? dDly + 1 : 0;
        expWb   = (!expNop && (ls ? mr : mrw)) ? 1 : 0;
        expLat  = (iDly + 1) + 1 + (cDly + 1) + expDmem + expWb + 1;

        bus.isLoadStore   = ls;
        bus.memRead       = mr;
        bus.memWrite      = mw;
        bus.memReadWrite  = mrw;
        bus.WBSrc         = wbs;
        bus.isALUOP       = !ls;
        bus.start         = 1'b1;
        bus.readInst_flag = 1'b1;

        while (cyc < 200) begin
            tick();
            cyc++;
            if (bus.imem_req) begin
                if (!reqSeen) begin
                    firstAddr = bus.imem_addr;
                    reqSeen   = 1'b1;
                end
                if (iWait == iDly) begin
                    bus.imem_ack   = 1'b1;
                    bus.imem_rdata = word;
                end else begin
                    bus.imem_ack   = 1'b0;
                    bus.imem_rdata = 16'($urandom);
                    iWait++;
                end
            end else begin
                bus.imem_ack = 1'b0;
            end
            if (bus.decodedInst) begin
                decSeen   = 1'b1;
                decodeCyc = cyc;
                if (bus.fetchNextInst) overlap++;
                cCnt = cDly;
                if (cDly == 0) bus.readInst_flag = 1'b0;
            end else if (decSeen && bus.readInst_flag) begin
                if (cCnt == 0) bus.readInst_flag = 1'b0;
                else cCnt--;
            end
            if (decodeCyc >= 0 && cyc == decodeCyc + 1) opSeen = bus.opcode;
            if (bus.dmem_req) begin
                dmemCyc++;
                if (bus.dmem_we !== mw) weBad++;
                if (stopInMem) bus.stop = 1'b1;
                bus.dmem_ack = (dmemCyc == dDly + 1);
            end else begin
                bus.dmem_ack = 1'b0;
            end
            if (bus.reg_we) begin
                regWeCnt++;
                if (bus.wb_sel !== wbs) selBad++;
            end
            if (bus.fetchNextInst) begin
                if (bus.decodedInst) overlap++;
                nextCnt++;
                fetchCyc = cyc;
                checkVal("retired_before_next", bus.retired_count, modelRetired);
                bus.readInst_flag = 1'b1;
                break;
            end
            if (bus.halted) begin
                halt = 1'b1;
                break;
            end
        end
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;

        checkVal("instr_done", nextCnt + int'(halt), 1);
        checkVal("fetch_req_seen", reqSeen, 1);
        checkVal("fetch_addr", firstAddr, modelPc);
        modelPc = modelPc + 1'b1;
        checkVal("decode_cycle", decodeCyc, iDly + 2);
        checkVal("opcode", opSeen, op);
        checkVal("no_overlap", overlap, 0);
        if (expTrap) begin
            checkVal("trap_halted", bus.halted, 1);
            checkVal("trap_illegal", bus.illegal, 1);
            checkVal("trap_no_retire", nextCnt, 0);
            checkVal("trap_retired_count", bus.retired_count, modelRetired);
        end else begin
            checkVal("latency", fetchCyc, expLat);
            checkVal("dmem_cycles", dmemCyc, expDmem);
            checkVal("dmem_we", weBad, 0);
            checkVal("reg_we_count", regWeCnt, expWb);
            checkVal("wb_sel", selBad, 0);
            modelRetired = modelRetired + 16'd1;
        end
    endtask

    initial begin
        int op;
        bit seen;

        clearInputs();
        rst = 1'b1;
        repeat (3) tick();
        checkVal("rst_busy", bus.busy, 0);
        checkVal("rst_imem_req", bus.imem_req, 0);
        checkVal("rst_imem_addr", bus.imem_addr, 0);
        checkVal("rst_opcode", bus.opcode, 0);
        checkVal("rst_ir", bus.ir, 0);
        checkVal("rst_retired", bus.retired_count, 0);
        checkVal("rst_strobes", {bus.decodedInst, bus.fetchNextInst, bus.dmem_req, bus.dmem_we,
                                 bus.reg_we, bus.wb_sel, bus.halted, bus.illegal}, 0);
        rst = 1'b0;

        // start and stop together: stop wins.
        bus.start = 1'b1;
        bus.stop = 1'b1;
        bus.readInst_flag = 1'b1;
        repeat (4) begin
            tick();
            checkVal("startstop_busy", bus.busy, 0);
            checkVal("startstop_imem_req", bus.imem_req, 0);
        end
        bus.stop = 1'b0;

        // ALU op 2 with writeback from result, immediate acks.
        runInstr(16'h2abc, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 0, 1'b0);
        // Load with dmem ack delayed 3 cycles.
        runInstr({OP_LOAD, 12'h123}, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 3, 1'b0);
        // Store: write enable, no writeback.
        runInstr({OP_STORE, 12'h456}, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1, 1, 1'b0);

        // Random traffic; enough instructions to wrap the 8-bit PC.
        for (int n = 0; n < 300; n++) begin
            op = $urandom_range(0, int'(OP_CMP));
            runInstr({4'(op), 12'($urandom)}, 1'($urandom), 1'($urandom), 1'($urandom),
                     1'($urandom), 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
                     $urandom_range(0, 3), 1'b0);
        end

        // stop raised during MEM: instruction completes, then IDLE with no more fetches.
        runInstr({OP_LOAD, 12'h0ff}, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 2, 1'b1);
        repeat (6) begin
            tick();
            checkVal("stop_idle_busy", bus.busy, 0);
            checkVal("stop_idle_imem_req", bus.imem_req, 0);
        end
        checkVal("stop_retired", bus.retired_count, modelRetired);

        // Reset while a load waits in MEM with its ack arriving on the reset edge.
        bus.stop = 1'b0;
        bus.start = 1'b1;
        bus.readInst_flag = 1'b1;
        bus.isLoadStore = 1'b1;
        bus.memRead = 1'b1;
        bus.memWrite = 1'b0;
        bus.imem_rdata = {OP_LOAD, 12'h005};
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            bus.imem_ack = bus.imem_req;
            if (bus.decodedInst) bus.readInst_flag = 1'b0;
            if (bus.dmem_req) seen = 1'b1;
        end
        checkVal("rst_mem_reached", seen, 1);
        bus.imem_ack = 1'b0;
        bus.start = 1'b0;
        tick();
        tick();
        bus.dmem_ack = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        modelPc = '0;
        modelRetired = '0;
        checkVal("rst_mid_dmem_req", bus.dmem_req, 0);
        checkVal("rst_mid_busy", bus.busy, 0);
        checkVal("rst_mid_pc", bus.imem_addr, 0);
        checkVal("rst_mid_retired", bus.retired_count, 0);
        tick();
        tick();
        checkVal("late_ack_busy", bus.busy, 0);
        checkVal("late_ack_retired", bus.retired_count, 0);
        checkVal("late_ack_dmem_req", bus.dmem_req, 0);
        bus.dmem_ack = 1'b0;

        // Opcode 14: trap or NOP depending on build.
        runInstr(16'he000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0, 1, 0, 1'b0);
`ifdef SEQ_ILLEGAL_TRAP_EN
        bus.start = 1'b1;
        bus.readInst_flag = 1'b1;
        repeat (5) begin
            tick();
            checkVal("halt_busy", bus.busy, 0);
            checkVal("halt_imem_req", bus.imem_req, 0);
            checkVal("halt_sticky", bus.halted, 1);
        end
`else
        checkVal("nop_illegal_tied", bus.illegal, 0);
        checkVal("nop_halted_tied", bus.halted, 0);
        runInstr(16'h3001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0);
`endif
        tick();
        checkVal("retired_final", bus.retired_count, modelRetired);

        $display("Simulation finished: %0d checks, %0d errors", checkCnt, errCnt);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Fetch/decode sequencer driving the control unit's `decodedInst`/`fetchNextInst` handshake. It fetches 16-bit instructions from instruction memory and presents the opcode. It then consumes the control unit's flags (`memRead`, `memWrite`, `memReadWrite`, `WBSrc`, `isALUOP`, `isLoadStore`, `readInst_flag`) to step data-memory access and register writeback. It sits between instruction memory, the control unit, and the datapath, and owns the PC and the instruction life cycle.

## Interface
- `AW`, 8: instruction address width; PC wraps modulo 2^AW.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: level; in IDLE, begin fetching at the current PC.
- `stop` in 1: level; sampled in NEXT, returns to IDLE after the current instruction retires.
- `readInst_flag`, `memRead`, `memWrite`, `memReadWrite`, `WBSrc`, `isALUOP`, `isLoadStore` in 1 each: flags from the control unit.
- `opcode` out 4: `ir[15:12]`, registered.
- `decodedInst` out 1: one-cycle pulse, opcode valid.
- `fetchNextInst` out 1: one-cycle pulse, instruction retired.
- `imem_addr` out AW: current PC.
- `imem_req` out 1: instruction memory request.
- `imem_ack` in 1: instruction memory acknowledge.
- `imem_rdata` in 16: instruction word.
- `ir` out 16: captured instruction.
- `dmem_req` out 1: data memory request.
- `dmem_we` out 1: data memory write enable.
- `dmem_ack` in 1: data memory acknowledge.
- `reg_we` out 1: one-cycle register-file write strobe.
- `wb_sel` out 1: writeback source (1 = memory/ALU result per `WBSrc`).
- `busy` out 1: high in any state other than IDLE/HALT.
- `halted` out 1: sticky.
- `illegal` out 1: sticky.
- `retired_count` out 16: retired-instruction counter, wraps.

## Operation
- States: IDLE, FETCH, DECODE, CTRL_WAIT, MEM, WB, NEXT, HALT.
- IDLE: if `start` & !`stop` & `readInst_flag`, go to FETCH. `stop` wins over `start`.
- FETCH: hold `imem_req`=1 and `imem_addr`=PC until `imem_ack`. On ack: `ir`←`imem_rdata`, PC←PC+1 (2^AW−1 wraps to 0), go to DECODE.
- DECODE: `opcode`←`ir[15:12]`, `decodedInst`=1 for exactly one cycle, go to CTRL_WAIT.
- CTRL_WAIT: wait while `readInst_flag`=1. Once it is 0:
  - `isLoadStore` → MEM.
  - else `memReadWrite` → WB.
  - else → NEXT.
- MEM: hold `dmem_req`=1 and `dmem_we`=`memWrite` until `dmem_ack`. Then `memRead` → WB, else → NEXT.
- WB: `reg_we`=1 for one cycle, `wb_sel`=`WBSrc`, go to NEXT.
- NEXT: `fetchNextInst`=1 for one cycle, `retired_count`+1. Then `stop` → IDLE, else → FETCH. FETCH waits for `readInst_flag`=1 before asserting `imem_req`.
- HALT: all strobes 0, PC frozen; left only by `rst`.

## Timing
- Reset values: all outputs 0, `opcode`=0, `ir`=0, PC=0, `retired_count`=0, state IDLE.
- `rst` mid-operation: outstanding requests are dropped at the same edge. Late acks are ignored outside FETCH/MEM.
- Best-case ALU instruction: imem ack same cycle → FETCH 1, DECODE 1, CTRL_WAIT 1, WB 1, NEXT 1 = 5 cycles per instruction.
- A load adds MEM (≥1 cycle). A store skips WB.
- `opcode` is stable from the cycle after DECODE until the next DECODE.
- Flags are sampled no earlier than the cycle after `decodedInst`.
- `decodedInst` and `fetchNextInst` are never high in the same cycle.

## Configuration
- `SEQ_ILLEGAL_TRAP_EN`:
  - Defined: opcodes 13–15 seen in CTRL_WAIT set `illegal`, retire nothing, and go to HALT with `halted`=1.
  - Undefined: opcodes 13–15 are treated as NOPs (straight to NEXT, counted as retired), and `illegal`/`halted` are tied 0.

## Structure
- Shared package `seq_pkg`: state enum, opcode localparams (LOAD=0, STORE=1, CMP=12, ILLEGAL_MIN=13), instruction width 16.
- Sub-module `seq_pc`: PC register with load/increment/wrap, parameterised by AW.

## Test plan
- Reset mid-MEM with `dmem_ack` pending → next cycle `dmem_req`=0, PC=0, state IDLE; a late ack has no effect.
- Opcode 2 at PC 0, flags `memReadWrite`=1, `WBSrc`=1, imem ack immediate → `decodedInst` at cycle 3, `reg_we`=1/`wb_sel`=1 at cycle 5, `fetchNextInst` at cycle 6, `retired_count`=1, PC=1.
- Load (opcode 0), `dmem_ack` delayed 3 cycles → `dmem_req` high 4 cycles with `dmem_we`=0, then `reg_we` pulse. Store (opcode 1) → `dmem_we`=1 and no `reg_we`.
- PC=2^AW−1 fetch → PC wraps to 0. 65536 retirements → `retired_count` wraps to 0.
- `stop` asserted during MEM → instruction completes, `fetchNextInst` pulses once, then IDLE with no further `imem_req`. `start`=`stop`=1 in IDLE → stays IDLE.
- Opcode 14:
  - with `SEQ_ILLEGAL_TRAP_EN` → `illegal`=1, `halted`=1, `retired_count` unchanged, `start` ignored;
  - without it → retired as NOP and the next fetch proceeds.
